// File: rtl/costas_acq_ctrl.sv
// -----------------------------------------------------------------------------
// costas_acq_ctrl -- acquisition sequencer for the Costas carrier-recovery loop.
//
// Steps a coarse NCO offset through a symmetric grid of 2*NSTEPS+1 bins
// (0, +STEP, -STEP, +2*STEP, ...), holding the loop disabled for SETTLE_CYC+1
// cycles after every offset change and enabled for up to LOCK_TO+1 cycles
// while waiting for lock. Once locked, a run of LOSS_CNT consecutive
// locked_i=0 cycles pulses relock_o and restarts the search.
//
// Build option: define COSTAS_ACQ_FAST_RELOCK_EN to restart after a loss of
// lock at the bin that was held, searching upward with one wrap through 0;
// FAIL follows once all 2*NSTEPS+1 bins have been tried. Without it, a
// loss of lock restarts the search at bin 0.
//
// Ports:
//   clk_i        clock
//   rst_ni       synchronous reset, active low
//   start_i      begin acquisition (accepted in IDLE and FAIL)
//   abort_i      return to IDLE, overrides everything else
//   locked_i     lock flag from the Costas loop
//   loop_enbl_o  loop enable (low while settling, idle or failed)
//   freq_off_o   signed coarse NCO offset, always the mapping of bin_o
//   bin_o        current grid index 0..2*NSTEPS
//   acq_done_o   high while locked
//   acq_fail_o   high while failed
//   relock_o     one-cycle pulse on loss-of-lock detection
// All outputs are registered.
// -----------------------------------------------------------------------------
module costas_acq_ctrl #(
  parameter logic signed [15:0] STEP       = 16'sd256,
  parameter int                 NSTEPS     = 8,
  parameter int                 SETTLE_CYC = 64,
  parameter int                 LOCK_TO    = 4096,
  parameter int                 LOSS_CNT   = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               locked_i,
  output logic               loop_enbl_o,
  output logic signed [15:0] freq_off_o,
  output logic [4:0]         bin_o,
  output logic               acq_done_o,
  output logic               acq_fail_o,
  output logic               relock_o
);

  localparam int         TMAX     = (SETTLE_CYC > LOCK_TO) ? SETTLE_CYC : LOCK_TO;
  localparam int         TW       = $clog2(TMAX + 1);
  localparam int         LW       = $clog2(LOSS_CNT + 1);
  localparam logic [4:0] LAST_BIN = 5'(2 * NSTEPS);

  if (NSTEPS < 1 || 2 * NSTEPS > 31) begin : g_bad_nsteps
    $error("costas_acq_ctrl: 2*NSTEPS must fit the 5-bit bin index");
  end
  if (STEP <= 0 || NSTEPS * int'(STEP) > 32767) begin : g_bad_step
    $error("costas_acq_ctrl: STEP must be >0 and NSTEPS*STEP <= 32767");
  end
  if (SETTLE_CYC < 1 || LOCK_TO < 1 || LOSS_CNT < 1) begin : g_bad_timing
    $error("costas_acq_ctrl: SETTLE_CYC, LOCK_TO and LOSS_CNT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_WAIT_LOCK, S_LOCKED, S_FAIL
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [LW-1:0]     loss_q, loss_d;
  logic [4:0]        bin_q, bin_d;
  logic              relock_d;
  logic              enbl_d, done_d, fail_d;
  logic signed [15:0] off_d;

  logic              search_done;
  logic [4:0]        next_bin;
  logic [4:0]        relock_bin;

  // k=0 -> 0, odd k -> +((k+1)/2)*STEP, even k -> -(k/2)*STEP.
  // (k+1)>>1 equals k/2 for even k, so one magnitude term serves both signs.
  function automatic logic signed [15:0] bin_to_off(input logic [4:0] k);
    logic [5:0]         kp;
    logic signed [15:0] mag;
    kp  = {1'b0, k} + 6'd1;
    mag = $signed({11'd0, kp[5:1]}) * STEP;
    return k[0] ? mag : -mag;
  endfunction

`ifdef COSTAS_ACQ_FAST_RELOCK_EN
  // Bins visited since the last restart; the start bin can be anywhere on
  // the grid, so exhaustion is judged by count rather than by bin index.
  logic [4:0] tried_q;

  assign search_done = (tried_q == LAST_BIN);
  assign next_bin    = (bin_q == LAST_BIN) ? 5'd0 : bin_q + 5'd1;
  assign relock_bin  = bin_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tried_q <= '0;
    end else if (state_d == S_SETTLE && state_q != S_SETTLE) begin
      tried_q <= (state_q == S_WAIT_LOCK) ? tried_q + 5'd1 : 5'd0;
    end
  end
`else
  assign search_done = (bin_q == LAST_BIN);
  assign next_bin    = bin_q + 5'd1;
  assign relock_bin  = 5'd0;
`endif

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      loss_q      <= '0;
      bin_q       <= '0;
      loop_enbl_o <= 1'b0;
      freq_off_o  <= '0;
      acq_done_o  <= 1'b0;
      acq_fail_o  <= 1'b0;
      relock_o    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      loss_q      <= loss_d;
      bin_q       <= bin_d;
      loop_enbl_o <= enbl_d;
      freq_off_o  <= off_d;
      acq_done_o  <= done_d;
      acq_fail_o  <= fail_d;
      relock_o    <= relock_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    loss_d   = '0;
    bin_d    = bin_q;
    relock_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_FAIL: begin
        if (start_i) begin
          state_d = S_SETTLE;
          timer_d = '0;
          bin_d   = '0;
        end
      end
      S_SETTLE: begin
        if (timer_q == TW'(SETTLE_CYC)) begin
          state_d = S_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        // Lock is tested first so it wins on the timeout cycle.
        if (locked_i) begin
          state_d = S_LOCKED;
          timer_d = '0;
        end else if (timer_q == TW'(LOCK_TO)) begin
          timer_d = '0;
          if (search_done) begin
            state_d = S_FAIL;
            bin_d   = '0;
          end else begin
            state_d = S_SETTLE;
            bin_d   = next_bin;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_LOCKED: begin
        if (!locked_i) begin
          if (loss_q == LW'(LOSS_CNT - 1)) begin
            state_d  = S_SETTLE;
            timer_d  = '0;
            bin_d    = relock_bin;
            relock_d = 1'b1;
          end else begin
            loss_d = loss_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
        bin_d   = '0;
      end
    endcase

    if (abort_i) begin
      state_d  = S_IDLE;
      timer_d  = '0;
      loss_d   = '0;
      bin_d    = '0;
      relock_d = 1'b0;
    end
  end

  // Output logic, computed from the next state so outputs can be registered
  // without lagging the state by a cycle.
  always_comb begin
    enbl_d = (state_d == S_WAIT_LOCK) || (state_d == S_LOCKED);
    done_d = (state_d == S_LOCKED);
    fail_d = (state_d == S_FAIL);
    off_d  = bin_to_off(bin_d);
  end

  assign bin_o = bin_q;

endmodule

// File: tb/tb_costas_acq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_costas_acq_ctrl -- scoreboard bench for costas_acq_ctrl.
// LOCK_TO is shortened to 512 to keep full-grid sweeps short; the other
// parameters keep their defaults. One bin therefore spans 65 SETTLE cycles
// plus 513 WAIT_LOCK cycles = 578 cycles.
// -----------------------------------------------------------------------------
module tb_costas_acq_ctrl;

  localparam int SETTLE_CYC = 64;
  localparam int LOCK_TO    = 512;
  localparam int SET_LEN    = SETTLE_CYC + 1;
  localparam int BIN_LEN    = SET_LEN + LOCK_TO + 1;

  logic               clk = 1'b0;
  logic               rst_n, start, abort, locked;
  logic               loop_enbl;
  logic signed [15:0] freq_off;
  logic [4:0]         bin;
  logic               acq_done, acq_fail, relock;

  costas_acq_ctrl #(
    .STEP(16'sd256), .NSTEPS(8), .SETTLE_CYC(SETTLE_CYC),
    .LOCK_TO(LOCK_TO), .LOSS_CNT(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .locked_i(locked), .loop_enbl_o(loop_enbl), .freq_off_o(freq_off),
    .bin_o(bin), .acq_done_o(acq_done), .acq_fail_o(acq_fail),
    .relock_o(relock)
  );

  always #5 clk = ~clk;

  // Hand-computed grid offsets for bins 0..16.
  int off_tbl [17] = '{0, 256, -256, 512, -512, 768, -768, 1024, -1024,
                       1280, -1280, 1536, -1536, 1792, -1792, 2048, -2048};

  typedef struct {
    string       name;
    logic [24:0] vec;  // {enbl, off[15:0], bin[4:0], done, fail, relock}
  } exp_t;

  exp_t exp_q [$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [24:0] act,
                       input logic [24:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got enbl=%0b off=%0d bin=%0d done=%0b fail=%0b relock=%0b, want enbl=%0b off=%0d bin=%0d done=%0b fail=%0b relock=%0b",
               name, act[24], $signed(act[23:8]), act[7:3], act[2], act[1], act[0],
               exp[24], $signed(exp[23:8]), exp[7:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: compares every pending expectation against the outputs at the
  // falling edge, away from the edge that updates them.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, {loop_enbl, freq_off, bin, acq_done, acq_fail, relock}, e.vec);
      end
    end
  end

  task automatic expect_out(input string name, input bit enbl, input int off,
                            input int b, input bit done, input bit fail,
                            input bit rl);
    exp_t e;
    e.name = name;
    e.vec  = {enbl, 16'(off), 5'(b), done, fail, rl};
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int rbin;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; locked = 1'b0;
    tick(2);
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    expect_out("idle_after_reset", 0, 0, 0, 0, 0, 0);

    // 1: full sweep with no lock ends in FAIL.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 17; k++) begin
      expect_out($sformatf("settle_bin%0d", k), 0, off_tbl[k], k, 0, 0, 0);
      if (k == 0) begin
        tick(SET_LEN - 1);
        expect_out("settle_last_cycle", 0, 0, 0, 0, 0, 0);
        tick();
      end else begin
        tick(SET_LEN);
      end
      expect_out($sformatf("wait_bin%0d_first", k), 1, off_tbl[k], k, 0, 0, 0);
      tick(LOCK_TO);
      expect_out($sformatf("wait_bin%0d_last", k), 1, off_tbl[k], k, 0, 0, 0);
      tick();
    end
    expect_out("fail_after_sweep", 0, 0, 0, 0, 1, 0);
    tick(3);
    expect_out("fail_holds", 0, 0, 0, 0, 1, 0);

    // 2: lock on the 10th WAIT_LOCK cycle of bin 3.
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_out("restart_from_fail", 0, 0, 0, 0, 0, 0);
    tick(3 * BIN_LEN + SET_LEN + 9);
    expect_out("bin3_wait_cycle10", 1, 512, 3, 0, 0, 0);
    locked = 1'b1;
    tick();
    expect_out("locked_bin3", 1, 512, 3, 1, 0, 0);

    // 3: 7-cycle drop tolerated, 8-cycle drop triggers relock.
    locked = 1'b0;
    tick(7);
    expect_out("drop7_still_locked", 1, 512, 3, 1, 0, 0);
    locked = 1'b1;
    tick(2);
    expect_out("restored_locked", 1, 512, 3, 1, 0, 0);
    locked = 1'b0;
    tick(7);
    expect_out("drop8_cycle7", 1, 512, 3, 1, 0, 0);
`ifdef COSTAS_ACQ_FAST_RELOCK_EN
    rbin = 3;
`else
    rbin = 0;
`endif
    tick();
    expect_out("relock_pulse", 0, off_tbl[rbin], rbin, 0, 0, 1);
    tick();
    expect_out("relock_one_cycle", 0, off_tbl[rbin], rbin, 0, 0, 0);

    // 4: abort together with start in WAIT_LOCK.
    tick(SET_LEN - 1);
    expect_out("relock_wait_lock", 1, off_tbl[rbin], rbin, 0, 0, 0);
    tick(5);
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    expect_out("abort_to_idle", 0, 0, 0, 0, 0, 0);
    tick(2);
    expect_out("idle_after_abort", 0, 0, 0, 0, 0, 0);

    // 5: reset mid-SETTLE at bin 5, then a clean restart from bin 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(5 * BIN_LEN + 30);
    expect_out("mid_settle_bin5", 0, 768, 5, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    expect_out("reset_mid_settle", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    expect_out("idle_after_mid_reset", 0, 0, 0, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    expect_out("restart_bin0", 0, 0, 0, 0, 0, 0);
    tick(SET_LEN);
    expect_out("restart_enable_latency", 1, 0, 0, 0, 0, 0);

    // 6: lock exactly on the timeout cycle of the last bin.
    tick(16 * BIN_LEN + LOCK_TO);
    expect_out("bin16_timeout_cycle", 1, -2048, 16, 0, 0, 0);
    locked = 1'b1;
    tick();
    expect_out("bin16_lock_wins", 1, -2048, 16, 1, 0, 0);
    tick(4);
    expect_out("bin16_lock_holds", 1, -2048, 16, 1, 0, 0);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
